// File: rtl/ascon_ctrl_fsm.sv
// Ascon AEAD control FSM: sequences init, AD, PT and finalisation phases of the
// permutation datapath. Defining ASCON_FSM_ABORT_EN adds the i_abort/o_aborted pair.
module ascon_ctrl_fsm #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int BLK_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_sys_enable,
  input  logic             i_start,
  input  logic             i_decrypt,
  input  logic [BLK_W-1:0] i_ad_blocks,
  input  logic [BLK_W-1:0] i_pt_blocks,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  output logic             o_busy,
  output logic             o_sel_init,
  output logic             o_state_en,
  output logic             o_perm_en,
  output logic [3:0]       o_round_idx,
  output logic             o_xor_data,
  output logic             o_replace_rate,
  output logic             o_xor_key_begin,
  output logic             o_xor_key_end,
  output logic             o_xor_dsep,
  output logic             o_cipher_en,
  output logic             o_cipher_valid,
  output logic             o_tag_en,
  output logic             o_done,
  output logic [3:0]       o_dbg_state
`ifdef ASCON_FSM_ABORT_EN
  ,
  input  logic             i_abort,
  output logic             o_aborted
`endif
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CONFIG, ST_INIT_RND, ST_INIT_END, ST_AD_WAIT, ST_AD_RND,
    ST_DSEP, ST_PT_WAIT, ST_PT_RND, ST_FIN_KEY, ST_FIN_RND, ST_FIN_END
  } state_e;

  localparam logic [3:0]       LAST_A = 4'(ROUNDS_A - 1);
  localparam logic [3:0]       LAST_B = 4'(ROUNDS_B - 1);
  localparam logic [3:0]       BASE_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0]       BASE_B = 4'(12 - ROUNDS_B);
  localparam logic [BLK_W-1:0] ONE    = BLK_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic [BLK_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [BLK_W-1:0] pt_cnt_q, pt_cnt_d;
  logic             decrypt_q, decrypt_d;
  logic             cipher_valid_q, cipher_valid_d;
  logic             force_idle;

`ifdef ASCON_FSM_ABORT_EN
  logic aborted_q, aborted_d;
  assign aborted_d  = i_abort && (state_q != ST_IDLE);
  assign force_idle = !i_sys_enable || aborted_d;
  assign o_aborted  = aborted_q;
`else
  assign force_idle = !i_sys_enable;
`endif

  assign o_cipher_valid = cipher_valid_q;
  assign o_dbg_state    = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      rcnt_q         <= '0;
      ad_cnt_q       <= '0;
      pt_cnt_q       <= '0;
      decrypt_q      <= 1'b0;
      cipher_valid_q <= 1'b0;
`ifdef ASCON_FSM_ABORT_EN
      aborted_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rcnt_q         <= rcnt_d;
      ad_cnt_q       <= ad_cnt_d;
      pt_cnt_q       <= pt_cnt_d;
      decrypt_q      <= decrypt_d;
      cipher_valid_q <= cipher_valid_d;
`ifdef ASCON_FSM_ABORT_EN
      aborted_q      <= aborted_d;
`endif
    end
  end

  // Data handshake: a word is consumed in the cycle where o_data_ready and
  // i_data_valid are both high; valid may rise or fall at any time, ready is
  // high for the whole of each WAIT state.
  always_comb begin
    state_d         = state_q;
    rcnt_d          = rcnt_q;
    ad_cnt_d        = ad_cnt_q;
    pt_cnt_d        = pt_cnt_q;
    decrypt_d       = decrypt_q;
    o_busy          = (state_q != ST_IDLE);
    o_data_ready    = 1'b0;
    o_sel_init      = 1'b0;
    o_state_en      = 1'b0;
    o_perm_en       = 1'b0;
    o_round_idx     = '0;
    o_xor_data      = 1'b0;
    o_replace_rate  = 1'b0;
    o_xor_key_begin = 1'b0;
    o_xor_key_end   = 1'b0;
    o_xor_dsep      = 1'b0;
    o_cipher_en     = 1'b0;
    o_tag_en        = 1'b0;
    o_done          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          decrypt_d = i_decrypt;
          ad_cnt_d  = i_ad_blocks;
          pt_cnt_d  = (i_pt_blocks == '0) ? ONE : i_pt_blocks;
          state_d   = ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        o_sel_init = 1'b1;
        o_state_en = 1'b1;
        state_d    = ST_INIT_RND;
      end
      ST_INIT_RND, ST_FIN_RND: begin
        o_perm_en   = 1'b1;
        o_state_en  = 1'b1;
        o_round_idx = BASE_A + rcnt_q;
        if (rcnt_q == LAST_A) begin
          rcnt_d  = '0;
          state_d = (state_q == ST_INIT_RND) ? ST_INIT_END : ST_FIN_END;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      ST_AD_RND, ST_PT_RND: begin
        o_perm_en   = 1'b1;
        o_state_en  = 1'b1;
        o_round_idx = BASE_B + rcnt_q;
        if (rcnt_q == LAST_B) begin
          rcnt_d = '0;
          if (state_q == ST_PT_RND) state_d = ST_PT_WAIT;
          else                      state_d = (ad_cnt_q != '0) ? ST_AD_WAIT : ST_DSEP;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      ST_INIT_END: begin
        o_xor_key_end = 1'b1;
        o_state_en    = 1'b1;
        state_d       = (ad_cnt_q != '0) ? ST_AD_WAIT : ST_DSEP;
      end
      ST_AD_WAIT: begin
        o_data_ready = 1'b1;
        if (i_data_valid) begin
          o_xor_data = 1'b1;
          o_state_en = 1'b1;
          ad_cnt_d   = ad_cnt_q - ONE;
          state_d    = ST_AD_RND;
        end
      end
      ST_DSEP: begin
        o_xor_dsep = 1'b1;
        o_state_en = 1'b1;
        state_d    = ST_PT_WAIT;
      end
      ST_PT_WAIT: begin
        o_data_ready = 1'b1;
        if (i_data_valid) begin
          o_xor_data     = !decrypt_q;
          o_replace_rate = decrypt_q;
          o_cipher_en    = 1'b1;
          o_state_en     = 1'b1;
          pt_cnt_d       = pt_cnt_q - ONE;
          // The last block goes straight to finalisation without a permutation.
          state_d        = (pt_cnt_q > ONE) ? ST_PT_RND : ST_FIN_KEY;
        end
      end
      ST_FIN_KEY: begin
        o_xor_key_begin = 1'b1;
        o_state_en      = 1'b1;
        state_d         = ST_FIN_RND;
      end
      ST_FIN_END: begin
        o_xor_key_end = 1'b1;
        o_state_en    = 1'b1;
        o_tag_en      = 1'b1;
        o_done        = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cipher_valid_d = o_cipher_en;

`ifdef ASCON_FSM_ABORT_EN
    if (i_abort) o_done = 1'b0;
`endif

    if (force_idle) begin
      state_d        = ST_IDLE;
      rcnt_d         = '0;
      ad_cnt_d       = '0;
      pt_cnt_d       = '0;
      cipher_valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: a phase-level model expands each operation into an
// expected per-cycle output trace, compared against two parameterisations.
module tb_ascon_ctrl_fsm;
  localparam int W = 18;
  localparam int B_DONE = 0, B_TAG = 1, B_CV = 2, B_CE = 3, B_DSEP = 4, B_KE = 5;
  localparam int B_KB = 6, B_REP = 7, B_XD = 8, B_IDX = 9, B_PERM = 13, B_SEN = 14;
  localparam int B_SINIT = 15, B_RDY = 16, B_BUSY = 17;
  localparam int CUT_NONE = 0, CUT_SE = 1, CUT_RST = 2, CUT_ABORT = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic       sys_en[2], start_s[2], dec_s[2], valid_s[2];
  logic [7:0] ad_s[2], pt_s[2];
  logic       ready_w[2], busy_w[2], sinit_w[2], sen_w[2], perm_w[2], xd_w[2];
  logic       rep_w[2], kb_w[2], ke_w[2], dsep_w[2], ce_w[2], cv_w[2], tag_w[2], done_w[2];
  logic [3:0] idx_w[2], dbg_w[2];
`ifdef ASCON_FSM_ABORT_EN
  logic       abort_s[2], aborted_w[2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ascon_ctrl_fsm #(
      .ROUNDS_A(g == 0 ? 12 : 8),
      .ROUNDS_B(g == 0 ? 6 : 4),
      .BLK_W   (8)
    ) u_dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .i_sys_enable   (sys_en[g]),
      .i_start        (start_s[g]),
      .i_decrypt      (dec_s[g]),
      .i_ad_blocks    (ad_s[g]),
      .i_pt_blocks    (pt_s[g]),
      .i_data_valid   (valid_s[g]),
      .o_data_ready   (ready_w[g]),
      .o_busy         (busy_w[g]),
      .o_sel_init     (sinit_w[g]),
      .o_state_en     (sen_w[g]),
      .o_perm_en      (perm_w[g]),
      .o_round_idx    (idx_w[g]),
      .o_xor_data     (xd_w[g]),
      .o_replace_rate (rep_w[g]),
      .o_xor_key_begin(kb_w[g]),
      .o_xor_key_end  (ke_w[g]),
      .o_xor_dsep     (dsep_w[g]),
      .o_cipher_en    (ce_w[g]),
      .o_cipher_valid (cv_w[g]),
      .o_tag_en       (tag_w[g]),
      .o_done         (done_w[g]),
      .o_dbg_state    (dbg_w[g])
`ifdef ASCON_FSM_ABORT_EN
      ,
      .i_abort        (abort_s[g]),
      .o_aborted      (aborted_w[g])
`endif
    );
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           vld_q[$];
  int n_checks = 0, n_pass = 0;
  int ad_rnd_idx, pt_wait_idx, fin_idx;
  int obs_done_idx, obs_done_cnt, obs_perm_cnt, obs_dsep_idx;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] obs(input int k);
    logic [W-1:0] o;
    o = '0;
    o[B_DONE] = done_w[k];  o[B_TAG] = tag_w[k];   o[B_CV] = cv_w[k];   o[B_CE] = ce_w[k];
    o[B_DSEP] = dsep_w[k];  o[B_KE] = ke_w[k];     o[B_KB] = kb_w[k];   o[B_REP] = rep_w[k];
    o[B_XD] = xd_w[k];      o[B_IDX +: 4] = idx_w[k];                   o[B_PERM] = perm_w[k];
    o[B_SEN] = sen_w[k];    o[B_SINIT] = sinit_w[k]; o[B_RDY] = ready_w[k]; o[B_BUSY] = busy_w[k];
    return o;
  endfunction

  // ---------------- reference model ----------------
  task automatic push(input logic [W-1:0] e, input bit v);
    exp_q.push_back(e);
    vld_q.push_back(v);
  endtask

  task automatic rounds(input int n);
    logic [W-1:0] e;
    for (int r = 0; r < n; r++) begin
      e = '0; e[B_BUSY] = 1; e[B_PERM] = 1; e[B_SEN] = 1; e[B_IDX +: 4] = 4'(12 - n + r);
      push(e, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic wait_phase(input int stall);
    logic [W-1:0] e;
    int n;
    n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    for (int s = 0; s < n; s++) begin
      e = '0; e[B_BUSY] = 1; e[B_RDY] = 1;
      push(e, 1'b0);
    end
  endtask

  task automatic build_trace(input int ra, input int rb, input int ad, input int pt,
                             input bit dec, input int stall);
    logic [W-1:0] e, t;
    int npt;
    exp_q.delete(); vld_q.delete();
    push('0, 1'($urandom_range(0, 1)));
    e = '0; e[B_BUSY] = 1; e[B_SINIT] = 1; e[B_SEN] = 1; push(e, 1'($urandom_range(0, 1)));
    rounds(ra);
    e = '0; e[B_BUSY] = 1; e[B_KE] = 1; e[B_SEN] = 1; push(e, 1'($urandom_range(0, 1)));
    for (int a = 0; a < ad; a++) begin
      wait_phase(stall);
      e = '0; e[B_BUSY] = 1; e[B_RDY] = 1; e[B_XD] = 1; e[B_SEN] = 1; push(e, 1'b1);
      if (a == 0) ad_rnd_idx = exp_q.size();
      rounds(rb);
    end
    e = '0; e[B_BUSY] = 1; e[B_DSEP] = 1; e[B_SEN] = 1; push(e, 1'($urandom_range(0, 1)));
    npt = (pt == 0) ? 1 : pt;
    for (int p = 0; p < npt; p++) begin
      if (p == 0) pt_wait_idx = exp_q.size();
      wait_phase(stall);
      e = '0; e[B_BUSY] = 1; e[B_RDY] = 1; e[B_SEN] = 1; e[B_CE] = 1;
      e[B_XD] = !dec; e[B_REP] = dec;
      push(e, 1'b1);
      if (p < npt - 1) rounds(rb);
    end
    e = '0; e[B_BUSY] = 1; e[B_KB] = 1; e[B_SEN] = 1; push(e, 1'($urandom_range(0, 1)));
    fin_idx = exp_q.size();
    rounds(ra);
    e = '0; e[B_BUSY] = 1; e[B_KE] = 1; e[B_SEN] = 1; e[B_TAG] = 1; e[B_DONE] = 1;
    push(e, 1'($urandom_range(0, 1)));
    push('0, 1'($urandom_range(0, 1)));
    // cipher_valid echoes cipher_en one cycle later
    for (int i = exp_q.size() - 1; i > 0; i--) begin
      t = exp_q[i]; t[B_CV] = exp_q[i-1][B_CE]; exp_q[i] = t;
    end
  endtask

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic run_trace(input int k, input int ad, input int pt, input bit dec,
                           input int cut, input int cut_kind);
    int n;
    n = exp_q.size();
    obs_done_idx = -1; obs_done_cnt = 0; obs_perm_cnt = 0; obs_dsep_idx = -1;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        start_s[k] = 1'b1; dec_s[k] = dec; ad_s[k] = 8'(ad); pt_s[k] = 8'(pt);
      end else begin
        start_s[k] = (i == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        dec_s[k] = 1'($urandom_range(0, 1));
        ad_s[k] = 8'($urandom_range(0, 255)); pt_s[k] = 8'($urandom_range(0, 255));
      end
      valid_s[k] = vld_q[i];
      sys_en[k]  = !(cut_kind == CUT_SE && i == cut);
`ifdef ASCON_FSM_ABORT_EN
      abort_s[k] = (cut_kind == CUT_ABORT && i == cut);
`endif
      @(negedge clock);
      check_eq($sformatf("trace[%0d]", i), 32'(obs(k)), 32'(exp_q[i]));
      if (done_w[k]) begin obs_done_cnt++; if (obs_done_idx < 0) obs_done_idx = i; end
      if (perm_w[k]) obs_perm_cnt++;
      if (dsep_w[k] && obs_dsep_idx < 0) obs_dsep_idx = i;
      if (cut_kind != CUT_NONE && i == cut) begin
        if (cut_kind == CUT_RST) begin
          reset_n = 1'b0;
          #1 check_eq("rst_async_zero", 32'(obs(k)), 32'd0);
          next_cycle();
          reset_n = 1'b1;
        end else begin
          next_cycle();
        end
        sys_en[k] = 1'b1; start_s[k] = 1'b0; valid_s[k] = 1'($urandom_range(0, 1));
`ifdef ASCON_FSM_ABORT_EN
        abort_s[k] = 1'b0;
`endif
        @(negedge clock);
        check_eq("cut_idle", 32'(obs(k)), 32'd0);
        if (done_w[k]) obs_done_cnt++;
`ifdef ASCON_FSM_ABORT_EN
        if (cut_kind == CUT_ABORT) check_eq("aborted_pulse", 32'(aborted_w[k]), 32'd1);
        next_cycle();
        @(negedge clock);
        if (cut_kind == CUT_ABORT) check_eq("aborted_clear", 32'(aborted_w[k]), 32'd0);
`endif
        next_cycle();
        return;
      end
      next_cycle();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, ad, pt, st;
    bit dec;
    reset_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      sys_en[j] = 1'b1; start_s[j] = 1'b0; dec_s[j] = 1'b0; valid_s[j] = 1'b0;
      ad_s[j] = '0; pt_s[j] = '0;
`ifdef ASCON_FSM_ABORT_EN
      abort_s[j] = 1'b0;
`endif
    end
    repeat (2) @(posedge clock);
    #1;
    for (int j = 0; j < 2; j++) begin
      check_eq($sformatf("reset_outputs%0d", j), 32'(obs(j)), 32'd0);
      check_eq($sformatf("reset_state%0d", j), 32'(dbg_w[j]), 32'd0);
    end
    reset_n = 1'b1;
    next_cycle();

    // Default configuration, 1 AD + 1 PT, encrypt, valid always ready.
    build_trace(12, 6, 1, 1, 1'b0, 0);
    run_trace(0, 1, 1, 1'b0, -1, CUT_NONE);
    check_eq("latency_done", 32'(obs_done_idx), 32'd37);
    check_eq("perm_cycles", 32'(obs_perm_cnt), 32'd30);
    check_eq("dsep_cycle", 32'(obs_dsep_idx), 32'd22);

    // No AD, three decrypt blocks.
    build_trace(12, 6, 0, 3, 1'b1, -1);
    run_trace(0, 0, 3, 1'b1, -1, CUT_NONE);

    // Reduced rounds instance, two AD blocks.
    build_trace(8, 4, 2, 1, 1'b0, -1);
    run_trace(1, 2, 1, 1'b0, -1, CUT_NONE);

    // Valid withheld for 5 cycles in every wait state.
    build_trace(12, 6, 1, 2, 1'b0, 5);
    run_trace(0, 1, 2, 1'b0, -1, CUT_NONE);

    // System enable dropped during FIN_RND round 3, then a fresh full run.
    build_trace(12, 6, 1, 1, 1'b0, 0);
    run_trace(0, 1, 1, 1'b0, fin_idx + 3, CUT_SE);
    check_eq("se_no_done", 32'(obs_done_cnt), 32'd0);
    build_trace(12, 6, 1, 1, 1'b0, 0);
    run_trace(0, 1, 1, 1'b0, -1, CUT_NONE);
    check_eq("latency_after_se", 32'(obs_done_idx), 32'd37);

    // Asynchronous reset in the middle of AD_RND.
    build_trace(12, 6, 1, 1, 1'b0, 0);
    run_trace(0, 1, 1, 1'b0, ad_rnd_idx + 2, CUT_RST);

`ifdef ASCON_FSM_ABORT_EN
    build_trace(12, 6, 1, 1, 1'b1, 2);
    run_trace(0, 1, 1, 1'b1, pt_wait_idx, CUT_ABORT);
    check_eq("abort_no_done", 32'(obs_done_cnt), 32'd0);
`endif

    // Randomised operations on both instances.
    for (int r = 0; r < 24; r++) begin
      k   = int'($urandom_range(0, 1));
      ad  = int'($urandom_range(0, 3));
      pt  = int'($urandom_range(0, 4));
      dec = 1'($urandom_range(0, 1));
      st  = (r % 4 == 0) ? int'($urandom_range(0, 6)) : -1;
      build_trace(k == 0 ? 12 : 8, k == 0 ? 6 : 4, ad, pt, dec, st);
      run_trace(k, ad, pt, dec, -1, CUT_NONE);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
